// File: rtl/dii_packet_buffer.sv
// dii_packet_buffer: store-and-forward flit buffer between the debug ring
// and a debug module. A packet is offered downstream only after its last
// flit has been stored, except when an oversize packet fills the buffer
// and must drain cut-through (flush) to avoid deadlock.
//
// Handshake: a flit moves on a rising edge when valid && ready are both
// high. Once out_valid rises it holds, with stable out_data/out_last, until
// accepted. in_ready and out_valid depend only on registered state.
module dii_packet_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    packet_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   level_q;
    logic [CW-1:0]   pkt_q;
    logic            flush;
    logic            wr_en;
    logic            rd_en;
    logic            pkt_inc;
    logic            pkt_dec;

    assign in_ready  = (level_q != CW'(DEPTH));
    assign out_valid = (level_q != '0) && ((pkt_q != '0) || flush);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;
    assign pkt_inc   = wr_en && in_last;
    assign pkt_dec   = rd_en && out_last;

    assign {out_last, out_data} = mem[rd_ptr];
    assign level        = level_q;
    assign packet_count = pkt_q;

    // Storage array: write {last, data} at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Fill level: net change of writes minus reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + CW'(1);
                2'b01:   level_q <= level_q - CW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Complete-packet count: last flits in minus last flits out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_q <= pkt_q + CW'(1);
                2'b01:   pkt_q <= pkt_q - CW'(1);
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    // Oversize escape: a full buffer with no complete packet drains
    // cut-through until the packet's last flit has been read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush <= 1'b0;
        end else if (pkt_dec) begin
            flush <= 1'b0;
        end else if ((level_q == CW'(DEPTH)) && (pkt_q == '0)) begin
            flush <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dii_packet_buffer.sv
module tb_dii_packet_buffer;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] level;
    logic [CW-1:0] packet_count;

    int errors = 0;
    int checks = 0;

    dii_packet_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .packet_count (packet_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // exp_q holds {last, data} of every stored flit in arrival order.
    logic [W:0] exp_q[$];
    logic [W:0] rx_q[$];
    logic       m_flush = 1'b0;

    function automatic int m_complete();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][W]) n++;
        return n;
    endfunction

    function automatic logic m_in_ready();
        return exp_q.size() != D;
    endfunction

    function automatic logic m_out_valid();
        return (exp_q.size() != 0) && ((m_complete() != 0) || m_flush);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_flush = 1'b0;
        end else begin
            logic wr, rd, head_last;
            wr = in_valid && m_in_ready();
            rd = m_out_valid() && out_ready;
            head_last = (exp_q.size() != 0) ? exp_q[0][W] : 1'b0;
            if (rd && head_last) m_flush = 1'b0;
            else if (exp_q.size() == D && m_complete() == 0) m_flush = 1'b1;
            if (rd) rx_q.push_back(exp_q.pop_front());
            if (wr) exp_q.push_back({in_last, in_data});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(m_in_ready()));
            check("out_valid", 32'(out_valid), 32'(m_out_valid()));
            check("level", 32'(level), 32'(exp_q.size()));
            check("packet_count", 32'(packet_count), 32'(m_complete()));
            if (m_out_valid()) begin
                check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
                check("out_last", 32'(out_last), 32'(exp_q[0][W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_level", 32'(level), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pkt", 32'(packet_count), 32'd0);
        rst = 1'b0;
        tick();

        // 3-flit packet, out_ready high throughout
        rx_q.delete();
        out_ready = 1'b1;
        send(16'h1001, 1'b0);
        check("t1_ov_low_1", 32'(out_valid), 32'd0);
        send(16'h1002, 1'b0);
        check("t1_ov_low_2", 32'(out_valid), 32'd0);
        send(16'h1003, 1'b1);
        check("t1_ov_high", 32'(out_valid), 32'd1);
        check("t1_first", 32'(out_data), 32'h1001);
        check("t1_pkt1", 32'(packet_count), 32'd1);
        tick(); tick(); tick();
        check("t1_rx_n", 32'(rx_q.size()), 32'd3);
        if (rx_q.size() == 3) begin
            check("t1_rx0", 32'(rx_q[0]), 32'h01001);
            check("t1_rx1", 32'(rx_q[1]), 32'h01002);
            check("t1_rx2", 32'(rx_q[2]), 32'h11003);
        end
        check("t1_pkt0", 32'(packet_count), 32'd0);

        // two 2-flit packets held, then released
        rx_q.delete();
        out_ready = 1'b0;
        send(16'h2001, 1'b0);
        send(16'h2002, 1'b1);
        send(16'h2003, 1'b0);
        send(16'h2004, 1'b1);
        check("t2_level", 32'(level), 32'd4);
        check("t2_pkt", 32'(packet_count), 32'd2);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t2_level0", 32'(level), 32'd0);
        check("t2_rx_n", 32'(rx_q.size()), 32'd4);
        foreach (rx_q[i]) check("t2_rx", 32'(rx_q[i][W-1:0]), 32'h2001 + 32'(i));

        // fill to full, release one, then stream across the wrap
        rx_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'h3000 + 16'(i), (i % 4) == 3);
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_full_level", 32'(level), 32'd16);
        check("t3_full_pkt", 32'(packet_count), 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_ready_back", 32'(in_ready), 32'd1);
        check("t3_level15", 32'(level), 32'd15);
        out_ready = 1'b1;
        for (int i = 16; i < 28; i++) send(16'h3000 + 16'(i), (i % 4) == 3);
        drain();
        check("t3_rx_n", 32'(rx_q.size()), 32'd28);
        foreach (rx_q[i]) begin
            check("t3_rx_data", 32'(rx_q[i][W-1:0]), 32'h3000 + 32'(i));
            check("t3_rx_last", 32'(rx_q[i][W]), 32'((i % 4) == 3));
        end

        // oversize 20-flit packet drains through flush
        rx_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(16'h4000 + 16'(i), 1'b0);
        check("t4_full_level", 32'(level), 32'd16);
        check("t4_full_pkt", 32'(packet_count), 32'd0);
        check("t4_full_ov", 32'(out_valid), 32'd0);
        tick();
        check("t4_flush_ov", 32'(out_valid), 32'd1);
        check("t4_flush_data", 32'(out_data), 32'h4000);
        for (int i = 16; i < 20; i++) send(16'h4000 + 16'(i), i == 19);
        drain();
        check("t4_rx_n", 32'(rx_q.size()), 32'd20);
        foreach (rx_q[i]) begin
            check("t4_rx_data", 32'(rx_q[i][W-1:0]), 32'h4000 + 32'(i));
            check("t4_rx_last", 32'(rx_q[i][W]), 32'(i == 19));
        end
        out_ready = 1'b0;
        send(16'h4100, 1'b0);
        check("t4_flush_cleared", 32'(out_valid), 32'd0);
        send(16'h4101, 1'b1);
        check("t4_stored_ov", 32'(out_valid), 32'd1);
        drain();

        // simultaneous last-write and last-read with one packet stored
        rx_q.delete();
        out_ready = 1'b0;
        send(16'h5001, 1'b1);
        out_ready = 1'b1;
        send(16'h5002, 1'b1);
        check("t5_pkt", 32'(packet_count), 32'd1);
        check("t5_level", 32'(level), 32'd1);
        check("t5_rx0", 32'(rx_q.size() > 0 ? rx_q[0] : '0), 32'h15001);
        check("t5_next", 32'(out_data), 32'h5002);
        drain();

        // reset in the middle of the second flit
        out_ready = 1'b0;
        send(16'h6001, 1'b0);
        in_data  = 16'h6002;
        in_last  = 1'b0;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t6_ov", 32'(out_valid), 32'd0);
        check("t6_ir", 32'(in_ready), 32'd1);
        check("t6_level", 32'(level), 32'd0);
        check("t6_pkt", 32'(packet_count), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_q.delete();
        out_ready = 1'b1;
        send(16'h7001, 1'b0);
        send(16'h7002, 1'b0);
        send(16'h7003, 1'b1);
        drain();
        check("t6_rx_n", 32'(rx_q.size()), 32'd3);
        foreach (rx_q[i]) begin
            check("t6_rx_data", 32'(rx_q[i][W-1:0]), 32'h7001 + 32'(i));
            check("t6_rx_last", 32'(rx_q[i][W]), 32'(i == 2));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dii_packet_buffer.md
# dii_packet_buffer

Store-and-forward packet buffer for the 16-bit DII debug interconnect. It sits directly downstream of the debug ring on a ring→module port, in front of a debug module such as the UART DEM or HIM. It accepts flits from the ring and presents a packet to the module only once the whole packet, up to and including its `last` flit, has been stored. This keeps slow modules from stalling the ring mid-packet.

## Interface
Parameters:
- `WIDTH`, default 16: flit width.
- `DEPTH`, default 16: storage in flits. Must be a power of 2 and at least 2.

Ports (`CW` = $clog2(DEPTH+1)):
- `clk`  in  1  clock; the block has one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  flit from the ring.
- `in_last`  in  1  marks the final flit of a packet.
- `in_valid`  in  1  input flit valid.
- `in_ready`  out  1  buffer can accept a flit.
- `out_data`  out  WIDTH  flit to the module.
- `out_last`  out  1  marks the final flit of a packet.
- `out_valid`  out  1  output flit valid.
- `out_ready`  in  1  module accepts the flit.
- `level`  out  CW  number of flits currently stored.
- `packet_count`  out  CW  number of complete packets stored.

## Operation
- Storage is a circular buffer of `DEPTH` entries, each holding {last, data}.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo `DEPTH`.
  - `level` is a separate counter.
- Write: on `in_valid && in_ready`, store {in_last, in_data} at the write pointer, then increment the write pointer.
- Read: on `out_valid && out_ready`, increment the read pointer. `out_data` and `out_last` are a combinational read at the read pointer.
- `in_ready = (level != DEPTH)`. There is no write bypass when full, even if a read happens in the same cycle.
- `level` update: +1 on write only, −1 on read only, unchanged on both or neither.
- `packet_count` update: +1 on a write with `in_last`, −1 on a read with `out_last`, unchanged when both happen in the same cycle.
- `out_valid = (level != 0) && (packet_count != 0 || flush)`.
- `flush` register (oversize-packet escape, prevents deadlock):
  - Set when `level == DEPTH && packet_count == 0`.
  - While set, flits drain cut-through.
  - Cleared on the read of a flit whose `last` bit is set.
  - Packets longer than `DEPTH` therefore pass through without deadlock, but are not stored-and-forwarded.
- `out_data` and `out_last` are don't-care when `out_valid` is 0.
- Flit order is preserved exactly. There is no reordering and no dropping.

## Timing
- Reset (asynchronous, takes effect immediately): pointers, `level`, `packet_count` and `flush` all go to 0. As a result `out_valid` = 0, `in_ready` = 1, `level` = 0 and `packet_count` = 0. Any partial or complete packets in storage are discarded.
- Latency: if a packet's last flit is written at clock edge N, `out_valid` is high in the cycle following edge N, with the packet's first flit on `out_data`. Minimum input-to-output latency is the packet length in cycles, plus 1.
- Throughput: 1 flit per cycle in each direction at the same time.
- Handshake: a transfer occurs at the rising edge when valid and ready are both high.
  - Once `out_valid` is asserted, it stays high with stable `out_data` and `out_last` until accepted. This holds because `packet_count` cannot drop without a read and `level` cannot drop without a read.
  - `in_ready` depends only on registers. There is no combinational path from `out_ready` to `in_ready`, nor from `in_valid` to `out_valid`.
- Full boundary: when `level == DEPTH`, `in_ready` = 0 for that cycle. A read in that cycle makes `in_ready` 1 on the next cycle.
- Empty boundary: when `level == 0`, `out_valid` = 0 regardless of `flush`.
- Wrap-around: pointers roll over from `DEPTH-1` to 0 with no bubble.

## Test plan
- Reset, then a 3-flit packet 0x1001, 0x1002, 0x1003 (last on the third) written in back-to-back cycles, with `out_ready` held at 1 → `out_valid` stays low through the third write edge and goes high the next cycle. The three flits appear on consecutive cycles with `out_last` only on 0x1003. `packet_count` goes 0→1→0.
- Two back-to-back 2-flit packets, with `out_ready` at 0 until both are stored → `level` = 4 and `packet_count` = 2. Then `out_ready` = 1 → four flits come out in order on consecutive cycles, and `level` returns to 0.
- With `DEPTH` = 16, write four 4-flit packets with `out_ready` at 0 → after 16 flits, `in_ready` = 0. Read one flit → `in_ready` = 1 on the next cycle. Continue streaming to push the pointers past the wrap, and check data integrity.
- Oversize packet of 20 flits (`DEPTH` = 16), `out_ready` at 1 → at `level` = 16 with `packet_count` = 0, `flush` sets and flits begin draining. All 20 flits arrive in order, and `flush` clears after the last flit is read.
- Simultaneous write of a last flit and read of a last flit while `packet_count` = 1 → `packet_count` stays 1 and `level` is unchanged.
- Assert `rst` in the middle of the second flit of a 3-flit packet → outputs go immediately to `out_valid` = 0, `in_ready` = 1, `level` = 0. A new packet written after reset is delivered intact, with no residue from the interrupted packet.
